// File: rtl/accel_pkg.sv
// Shared types for the vector processing unit.
//   q31_t              signed Q1.31 element
//   Q31_MAX / Q31_MIN  representable limits of q31_t
//   vpu_op_e           command opcode (encodings 6 and 7 are illegal)
//   vpu_state_e        control FSM states
//   is_legal_op()      opcode legality test
//   q31_mul_round()    Q1.31 product, rounded half up, kept wide for range checks
package accel_pkg;

  typedef logic signed [31:0] q31_t;

  localparam q31_t Q31_MAX = 32'sh7FFF_FFFF;
  localparam q31_t Q31_MIN = 32'sh8000_0000;

  typedef enum logic [2:0] {
    OP_COPY  = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_MUL   = 3'd3,
    OP_SCALE = 3'd4,
    OP_RELU  = 3'd5
  } vpu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } vpu_state_e;

  function automatic logic is_legal_op(vpu_op_e op);
    case (op)
      OP_COPY, OP_ADD, OP_SUB, OP_MUL, OP_SCALE, OP_RELU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // The only overflowing case is (-1.0 * -1.0), which lands on +2^31 after
  // the shift; the 64-bit result lets the caller see that.
  function automatic logic signed [63:0] q31_mul_round(q31_t a, q31_t b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return (p + 64'sd1073741824) >>> 31;
  endfunction

endpackage

// File: rtl/vector_proc_unit_if.sv
// Command/status bundle of the vector processing unit.
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               operation
//   cmd_src              peer unit supplying operand B
//   cmd_scalar           Q1.31 multiplier for OP_SCALE
//   done                 one-cycle completion pulse
//   err, sat             status, valid only while done=1
// master: command issuer; slave: the unit.
interface vector_proc_unit_if
  import accel_pkg::*;
#(
  parameter int UNIT_COUNT = 4
);
  localparam int SRC_W = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  vpu_op_e          cmd_op;
  logic [SRC_W-1:0] cmd_src;
  q31_t             cmd_scalar;
  logic             done;
  logic             err;
  logic             sat;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_scalar,
    input  cmd_ready, done, err, sat
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_scalar,
    output cmd_ready, done, err, sat
  );

endinterface

// File: rtl/vpu_lane_alu.sv
// One element of the vector datapath (purely combinational).
//   op      operation
//   a, b    local and peer operand
//   scalar  multiplier for OP_SCALE
//   r       Q1.31 result
//   sat     result was clamped
// Build option VPU_SAT_EN: clamp out-of-range results to [Q31_MIN, Q31_MAX]
// and flag them; otherwise results wrap to their low 32 bits and sat is 0.
module vpu_lane_alu
  import accel_pkg::*;
(
  input  vpu_op_e op,
  input  q31_t    a,
  input  q31_t    b,
  input  q31_t    scalar,
  output q31_t    r,
  output logic    sat
);

  // Every operation is evaluated at 64 bits so one range check covers all.
  logic signed [63:0] wide;

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    wide = '0;
    case (op)
      OP_COPY:  wide = 64'(b);
      OP_ADD:   wide = 64'(33'(a) + 33'(b));
      OP_SUB:   wide = 64'(33'(a) - 33'(b));
      OP_MUL:   wide = q31_mul_round(a, b);
      OP_SCALE: wide = q31_mul_round(a, scalar);
      OP_RELU:  wide = a[31] ? '0 : 64'(a);
      default:  wide = '0;  // illegal opcode writes zeros
    endcase
  end

`ifdef VPU_SAT_EN
  logic ovf;

  always_comb begin
    ovf = (wide > 64'(Q31_MAX)) || (wide < 64'(Q31_MIN));
    sat = ovf;
    if (!ovf)         r = wide[31:0];
    else if (wide[63]) r = Q31_MIN;
    else               r = Q31_MAX;
  end
`else
  logic unused_wide_hi;

  assign r              = wide[31:0];
  assign sat            = 1'b0;
  assign unused_wide_hi = ^wide[63:32];
`endif

endmodule

// File: rtl/vector_proc_unit.sv
// Vector processing unit: runs one command over a DEPTH-element Q1.31 vector,
// LANES elements per cycle, then pulses done.
//   clk, rst  clock; synchronous active-high reset
//   cmd       command/status bundle (vector_proc_unit_if.slave)
//   data_in   local operand A
//   peer_in   UNIT_COUNT peer vectors; cmd_src picks operand B
//   data_out  registered result vector
// Build option VPU_SAT_EN: saturating arithmetic (see vpu_lane_alu).
// Accept -> done takes DEPTH/LANES+1 cycles; operands are snapshotted on accept.
module vector_proc_unit
  import accel_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int LANES      = 4,
  parameter int UNIT_COUNT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  vector_proc_unit_if.slave                cmd,
  input  q31_t [DEPTH-1:0]                 data_in,
  input  q31_t [UNIT_COUNT-1:0][DEPTH-1:0] peer_in,
  output q31_t [DEPTH-1:0]                 data_out
);

  localparam int BEATS  = DEPTH / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  vpu_state_e        state, state_next;
  logic [BEAT_W-1:0] beat;
  q31_t [DEPTH-1:0]  a_q, b_q, data_q;
  vpu_op_e           op_q;
  q31_t              scalar_q;
  logic              sat_q;

  logic              accept, exec_en, ready_c, done_c;
  logic [IDX_W-1:0]  base;
  logic [IDX_W-1:0]  lane_idx [LANES];
  q31_t [LANES-1:0]  lane_r;
  logic [LANES-1:0]  lane_sat;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    accept     = 1'b0;
    exec_en    = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (cmd.cmd_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        exec_en = 1'b1;
        if (beat == BEAT_W'(BEATS - 1)) state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd.cmd_ready = ready_c;
  assign cmd.done      = done_c;
  assign cmd.err       = done_c & ~is_legal_op(op_q);
  assign cmd.sat       = done_c & sat_q;

  // ---------------- operand snapshot ----------------
  // NOTE: the snapshot registers carry no reset: EXEC is only reachable through accept, which loads them first.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q      <= data_in;
      b_q      <= peer_in[cmd.cmd_src];
      op_q     <= cmd.cmd_op;
      scalar_q <= cmd.cmd_scalar;
    end
  end

  // ---------------- lanes ----------------
  assign base = IDX_W'(beat) * IDX_W'(LANES);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = base + IDX_W'(l);

    vpu_lane_alu u_alu (
      .op     (op_q),
      .a      (a_q[lane_idx[l]]),
      .b      (b_q[lane_idx[l]]),
      .scalar (scalar_q),
      .r      (lane_r[l]),
      .sat    (lane_sat[l])
    );
  end

  // ---------------- beat counter, result, sticky sat ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat   <= '0;
      sat_q  <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      beat  <= '0;
      sat_q <= 1'b0;
    end else if (exec_en) begin
      beat  <= beat + BEAT_W'(1);
      sat_q <= sat_q | (|lane_sat);
      // Only this beat's slice is written; other elements hold their value.
      for (int l = 0; l < LANES; l++) data_q[lane_idx[l]] <= lane_r[l];
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_vector_proc_unit.sv
// Self-checking bench for vector_proc_unit (DEPTH=16, LANES=4, UNIT_COUNT=4).
// Stimulus pushes hand-computed expected results into a queue; a monitor pops
// and compares whenever done is seen. Expectations follow VPU_SAT_EN.
module tb_vector_proc_unit;
  import accel_pkg::*;

  localparam int DEPTH      = 16;
  localparam int LANES      = 4;
  localparam int UNIT_COUNT = 4;
  localparam int SRC_W      = 2;
  localparam int LAT        = DEPTH / LANES + 1;

`ifdef VPU_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif
  // Result for a true value of +2^31 and of -2^31-1.
  localparam q31_t POS_OVF = SAT_BUILD ? 32'h7FFF_FFFF : 32'h8000_0000;
  localparam q31_t NEG_OVF = SAT_BUILD ? 32'h8000_0000 : 32'h7FFF_FFFF;

  typedef q31_t [DEPTH-1:0] vec_t;
  typedef struct {
    string name;
    vec_t  data;
    logic  err;
    logic  sat;
  } exp_t;

  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  vec_t                             data_in;
  q31_t [UNIT_COUNT-1:0][DEPTH-1:0] peer_in;
  vec_t                             data_out;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  vector_proc_unit_if #(.UNIT_COUNT(UNIT_COUNT)) vif ();

  vector_proc_unit #(
    .DEPTH      (DEPTH),
    .LANES      (LANES),
    .UNIT_COUNT (UNIT_COUNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (vif.slave),
    .data_in  (data_in),
    .peer_in  (peer_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    int bad;
    bad = -1;
    checks++;
    for (int i = DEPTH - 1; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: element %0d got %08h expected %08h", name, bad, act[bad], exp[bad]);
    end
  endtask

  function automatic vec_t pat4(q31_t p0, q31_t p1, q31_t p2, q31_t p3);
    vec_t v;
    for (int i = 0; i < DEPTH; i++) begin
      case (i % 4)
        0:       v[i] = p0;
        1:       v[i] = p1;
        2:       v[i] = p2;
        default: v[i] = p3;
      endcase
    end
    return v;
  endfunction

  function automatic exp_t mk_exp(string name, vec_t data, logic err, logic sat);
    exp_t e;
    e.name = name;
    e.data = data;
    e.err  = err;
    e.sat  = sat;
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (vif.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding, expected done=0");
      end else begin
        e = exp_q.pop_front();
        check_vec({e.name, "_data"}, data_out, e.data);
        check({e.name, "_err"}, 64'(vif.err), 64'(e.err));
        check({e.name, "_sat"}, 64'(vif.sat), 64'(e.sat));
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (vif.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_ready"}, 64'(ok), 64'd1);
  endtask

  // Issues one command, scrambles every input right after accept, waits for done.
  task automatic run_cmd(input string name, input vpu_op_e op, input logic [SRC_W-1:0] src,
                         input q31_t scalar, input vec_t a, input vec_t b,
                         input vec_t exp, input logic e_err, input logic e_sat);
    int lat;
    data_in        = a;
    peer_in[src]   = b;
    vif.cmd_op     = op;
    vif.cmd_src    = src;
    vif.cmd_scalar = scalar;
    vif.cmd_valid  = 1'b1;
    exp_q.push_back(mk_exp(name, exp, e_err, e_sat));
    wait_ready(name);
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vif.cmd_valid  = 1'b0;
        data_in        = ~a;
        peer_in[src]   = ~b;
        vif.cmd_scalar = ~scalar;
        vif.cmd_op     = OP_ADD;
        vif.cmd_src    = src + 1'b1;
      end
      if (vif.done) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(LAT));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    vec_t v_copy;
    int   done_k, rdy_k, lat2;

    vif.cmd_valid  = 1'b0;
    vif.cmd_op     = OP_COPY;
    vif.cmd_src    = '0;
    vif.cmd_scalar = '0;
    data_in        = '0;
    for (int u = 0; u < UNIT_COUNT; u++)
      for (int i = 0; i < DEPTH; i++)
        peer_in[u][i] = {8'(8'h30 + u), 24'(i)};
    for (int i = 0; i < DEPTH; i++) v_copy[i] = {8'hA5, 24'(i)};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(vif.cmd_ready), 64'd1);
    check("rst_done", 64'(vif.done), 64'd0);
    check("rst_err", 64'(vif.err), 64'd0);
    check("rst_sat", 64'(vif.sat), 64'd0);
    check_vec("rst_data_out", data_out, '0);
    rst = 1'b0;
    @(negedge clk);

    // Latency, back-to-back accept with cmd_valid held high, input changes after accept
    data_in        = pat4(32'd1, 32'd2, 32'd3, 32'd4);
    peer_in[0]     = pat4(32'd10, 32'd20, 32'd30, 32'd40);
    vif.cmd_op     = OP_ADD;
    vif.cmd_src    = 2'd0;
    vif.cmd_valid  = 1'b1;
    exp_q.push_back(mk_exp("b2b_first", pat4(32'd11, 32'd22, 32'd33, 32'd44), 1'b0, 1'b0));
    check("b2b_ready_idle", 64'(vif.cmd_ready), 64'd1);
    @(posedge clk);
    done_k = -1;
    rdy_k  = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        data_in     = pat4(32'h50, 32'h60, 32'h70, 32'h80);
        peer_in[0]  = pat4(32'h7777_7777, 32'h7777_7777, 32'h7777_7777, 32'h7777_7777);
        peer_in[2]  = pat4(32'h10, 32'h20, 32'h30, 32'h90);
        vif.cmd_op  = OP_SUB;
        vif.cmd_src = 2'd2;
        exp_q.push_back(mk_exp("b2b_second", pat4(32'h40, 32'h40, 32'h40, 32'hFFFF_FFF0), 1'b0, 1'b0));
      end
      if (vif.done && done_k < 0) done_k = k;
      if (vif.cmd_ready) begin
        rdy_k = k;
        break;
      end
    end
    check("b2b_done_cycle", 64'(done_k), 64'd5);
    check("b2b_next_accept_cycle", 64'(rdy_k), 64'd6);
    @(posedge clk);
    lat2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vif.cmd_valid = 1'b0;
        data_in       = '0;
      end
      if (vif.done) begin
        lat2 = k;
        break;
      end
    end
    check("b2b_second_latency", 64'(lat2), 64'(LAT));

    // Arithmetic
    run_cmd("add", OP_ADD, 2'd1, 32'd0,
            pat4(32'h4000_0000, 32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF),
            pat4(32'h4000_0000, 32'd3, 32'd1, 32'd1),
            pat4(POS_OVF, 32'd8, 32'd0, POS_OVF), 1'b0, SAT_BUILD);
    run_cmd("sub", OP_SUB, 2'd2, 32'd0,
            pat4(32'h8000_0000, 32'd10, 32'd0, 32'h7FFF_FFFF),
            pat4(32'd1, 32'd3, 32'd1, 32'hFFFF_FFFF),
            pat4(NEG_OVF, 32'd7, 32'hFFFF_FFFF, POS_OVF), 1'b0, SAT_BUILD);
    run_cmd("mul", OP_MUL, 2'd0, 32'd0,
            pat4(32'h8000_0000, 32'h4000_0000, 32'hC000_0000, 32'd1),
            pat4(32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000),
            pat4(POS_OVF, 32'h2000_0000, 32'hE000_0000, 32'd1), 1'b0, SAT_BUILD);
    run_cmd("mul_round", OP_MUL, 2'd3, 32'd0,
            pat4(32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0),
            pat4(32'h3FFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF, 32'h1234_5678),
            pat4(32'd0, 32'd0, 32'h7FFF_FFFE, 32'd0), 1'b0, 1'b0);
    run_cmd("scale", OP_SCALE, 2'd0, 32'h4000_0000,
            pat4(32'h4000_0000, 32'h2000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF),
            pat4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
            pat4(32'h2000_0000, 32'h1000_0000, 32'hFFFF_FFFF, 32'h4000_0000), 1'b0, 1'b0);
    run_cmd("relu", OP_RELU, 2'd1, 32'd0,
            pat4(32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF),
            pat4(32'd9, 32'd9, 32'd9, 32'd9),
            pat4(32'd0, 32'd1, 32'd0, 32'h7FFF_FFFF), 1'b0, 1'b0);
    run_cmd("copy_src3", OP_COPY, 2'd3, 32'd0,
            pat4(32'd1, 32'd2, 32'd3, 32'd4), v_copy, v_copy, 1'b0, 1'b0);
    run_cmd("illegal_op7", vpu_op_e'(3'd7), 2'd1, 32'd0,
            pat4(32'd5, 32'd6, 32'd7, 32'd8),
            pat4(32'd1, 32'd1, 32'd1, 32'd1),
            '0, 1'b1, 1'b0);
    run_cmd("copy_src2", OP_COPY, 2'd2, 32'd0,
            pat4(32'd0, 32'd0, 32'd0, 32'd0),
            pat4(32'h0BAD_F00D, 32'h1, 32'h2, 32'h3),
            pat4(32'h0BAD_F00D, 32'h1, 32'h2, 32'h3), 1'b0, 1'b0);

    // Reset during EXEC beat 2: no done pulse, outputs cleared
    data_in       = pat4(32'd1, 32'd1, 32'd1, 32'd1);
    peer_in[1]    = pat4(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    vif.cmd_op    = OP_COPY;
    vif.cmd_src   = 2'd1;
    vif.cmd_valid = 1'b1;
    wait_ready("rst_abort");
    @(posedge clk);
    @(negedge clk);
    vif.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_vec("rst_abort_data_out", data_out, '0);
    check("rst_abort_cmd_ready", 64'(vif.cmd_ready), 64'd1);
    check("rst_abort_done", 64'(vif.done), 64'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    run_cmd("after_rst", OP_ADD, 2'd1, 32'd0,
            pat4(32'd1, 32'd2, 32'd3, 32'd4),
            pat4(32'h10, 32'h20, 32'h30, 32'h40),
            pat4(32'h11, 32'h22, 32'h33, 32'h44), 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

endmodule
